sprite_anim_mapper: RTL
=======================

SPRITE_ANIM_MAPPER -- requirements
Module: sprite_anim_mapper

Interface
REQ-001 SHALL have parameter SPR_W, default 40: sprite width in texels.
REQ-002 SHALL have parameter SPR_H, default 66: sprite height in texels.
REQ-003 SHALL have parameter FRAMES, default 6: number of animation frames stored consecutively in ROM.
REQ-004 SHALL have parameter SCALE_LOG2, default 0: each texel drawn as 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels.
REQ-005 SHALL have parameter FRAME_DIV, default 4: vsync pulses per animation step.
REQ-006 SHALL have parameter IDX_W, default 4: palette index width; TRANSP_IDX, default 0: transparent index.
REQ-007 SHALL have parameter ADDR_W, default 14: ROM address width; must hold SPR_W*SPR_H*FRAMES-1.
REQ-008 vga_clk  in  1  pixel clock; all state on its rising edge.
REQ-009 reset_n  in  1  asynchronous, active-low reset.
REQ-010 DrawX, DrawY  in  10 each  current pixel coordinate.
REQ-011 blank  in  1  1 = active video.
REQ-012 vsync_pulse  in  1  one-cycle frame-start strobe.
REQ-013 pos_x, pos_y  in  10 each  sprite top-left; flip_h  in  1  mirror horizontally; anim_en  in  1  advance animation.
REQ-014 rom_address  out  ADDR_W  to external 1-cycle-latency ROM; rom_q  in  IDX_W  ROM data.
REQ-015 pal_index  out  IDX_W  to combinational palette; pal_red, pal_green, pal_blue  in  4 each.
REQ-016 red, green, blue  out  4 each  pixel colour; hit  out  1  opaque sprite pixel.

Function
REQ-017 SHALL latch pos_x, pos_y, flip_h into shadow registers only on cycles where vsync_pulse=1; all drawing uses shadow values.
REQ-018 SHALL count vsync pulses in a divider 0..FRAME_DIV-1 while anim_en=1; on wrap, frame index increments; frame FRAMES-1 wraps to 0.
REQ-019 SHALL hold divider and frame index when anim_en=0.
REQ-020 Stage 1 (edge N+1): register in_box = DrawX in [px, px+(SPR_W<<SCALE_LOG2)) and DrawY in [py, py+(SPR_H<<SCALE_LOG2)), computed in 11-bit unsigned arithmetic (no wrap), plus blank delay.
REQ-021 Stage 1 SHALL register rom_address = frame*SPR_W*SPR_H + row*SPR_W + col, row=(DrawY-py)>>SCALE_LOG2, col=(DrawX-px)>>SCALE_LOG2, or SPR_W-1-col when mirrored; rom_address=0 when not in_box.
REQ-022 Stage 2 (edge N+2): rom_q valid; pal_index = rom_q; in_box and blank delayed one more cycle.
REQ-023 Stage 3 (edge N+3): if delayed blank=1, in_box=1 and rom_q != TRANSP_IDX then red/green/blue = pal_*, hit=1; else all 0, hit=0.
REQ-024 Total latency DrawX/DrawY to red/green/blue/hit SHALL be exactly 3 vga_clk cycles, one pixel per cycle, no stalls.
REQ-025 Sprite partly off-screen (pos_x+width > 639) SHALL draw visible part only; no wrap to left edge.
REQ-026 vsync_pulse coinciding with divider wrap SHALL both latch position and advance frame in the same cycle.

Reset
REQ-027 While reset_n=0: red, green, blue, hit, rom_address, pipeline valids = 0; frame index, divider = 0; shadow pos_x, pos_y = 0; shadow flip = 0.
REQ-028 Reset asserted mid-line SHALL clear outputs asynchronously; first valid pixel 3 cycles after deassertion.

Configuration
REQ-029 With SPRITE_HFLIP_EN defined, flip_h SHALL mirror per REQ-021; without it, flip_h port SHALL remain but be ignored (col never mirrored) and its shadow register omitted.

Verification
REQ-030 Reset, pos=(100,50), blank=1, DrawX=100,DrawY=50, ROM[0]=3 -> after 3 cycles hit=1, rgb=palette[3].
REQ-031 ROM texel index = TRANSP_IDX at in-box pixel -> hit=0, rgb=0; DrawX=99 -> hit=0, rom_address=0.
REQ-032 anim_en=1, FRAME_DIV=4, 24 vsync pulses -> frame goes 0..5 then 0; address at top-left of frame 2 = 2*2640=5280.
REQ-033 SPRITE_HFLIP_EN defined, flip_h=1 latched, DrawX=pos_x -> rom_address=39; undefined -> 0.
REQ-034 SCALE_LOG2=1, pos=(0,0), DrawX=3,DrawY=5 -> col=1,row=2, rom_address=81; DrawX=80 -> hit=0.
REQ-035 pos_x changed mid-frame without vsync_pulse -> output unchanged until next vsync_pulse.

Source files
------------

// File: rtl/sprite_anim_mapper.sv
// Sprite animation mapper: 3-stage pixel pipeline (box test + ROM address, ROM read, colour out).
// Horizontal mirroring via flip_h is compiled in only when SPRITE_HFLIP_EN is defined.
module sprite_anim_mapper #(
    parameter int SPR_W      = 40,
    parameter int SPR_H      = 66,
    parameter int FRAMES     = 6,
    parameter int SCALE_LOG2 = 0,
    parameter int FRAME_DIV  = 4,
    parameter int IDX_W      = 4,
    parameter int TRANSP_IDX = 0,
    parameter int ADDR_W     = 14
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              vsync_pulse,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              flip_h,
    input  logic              anim_en,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              hit
);

    localparam int FRM_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int FRAME_SZ = SPR_W * SPR_H;
    localparam logic [10:0] BOX_W = 11'(SPR_W << SCALE_LOG2);
    localparam logic [10:0] BOX_H = 11'(SPR_H << SCALE_LOG2);

    logic [9:0]        pos_x_q, pos_x_d;
    logic [9:0]        pos_y_q, pos_y_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [FRM_W-1:0]  frame_q, frame_d;
    logic              in_box1_q, in_box1_d;
    logic              blank1_q, blank1_d;
    logic              in_box2_q, in_box2_d;
    logic              blank2_q, blank2_d;
    logic [ADDR_W-1:0] rom_address_q, rom_address_d;
    logic [3:0]        red_q, red_d;
    logic [3:0]        green_q, green_d;
    logic [3:0]        blue_q, blue_d;
    logic              hit_q, hit_d;
    logic              flip_cur;

`ifdef SPRITE_HFLIP_EN
    logic flip_q, flip_d;
    assign flip_cur = flip_q;
    always_comb begin
        flip_d = flip_q;
        if (vsync_pulse) flip_d = flip_h;
    end
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) flip_q <= 1'b0;
        else          flip_q <= flip_d;
    end
`else
    logic unused_flip;
    assign unused_flip = flip_h;
    assign flip_cur    = 1'b0;
`endif

    // Shadow position and animation step only move at frame start so a frame is drawn consistently.
    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        div_d   = div_q;
        frame_d = frame_q;
        if (vsync_pulse) begin
            pos_x_d = pos_x;
            pos_y_d = pos_y;
            if (anim_en) begin
                if (div_q == DIV_W'(FRAME_DIV - 1)) begin
                    div_d   = '0;
                    frame_d = (frame_q == FRM_W'(FRAMES - 1)) ? '0 : frame_q + FRM_W'(1);
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
        end
    end

    logic [10:0] dx, dy, col, row, col_m;
    logic [ADDR_W-1:0] addr;

    // Stage 1: 11-bit box test so a sprite near the right/bottom edge never wraps around.
    always_comb begin
        dx        = {1'b0, DrawX} - {1'b0, pos_x_q};
        dy        = {1'b0, DrawY} - {1'b0, pos_y_q};
        in_box1_d = ({1'b0, DrawX} >= {1'b0, pos_x_q}) &&
                    ({1'b0, DrawX} <  ({1'b0, pos_x_q} + BOX_W)) &&
                    ({1'b0, DrawY} >= {1'b0, pos_y_q}) &&
                    ({1'b0, DrawY} <  ({1'b0, pos_y_q} + BOX_H));
        col       = dx >> SCALE_LOG2;
        row       = dy >> SCALE_LOG2;
        col_m     = flip_cur ? (11'(SPR_W - 1) - col) : col;
        addr      = ADDR_W'(frame_q) * ADDR_W'(FRAME_SZ) +
                    ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col_m);
        rom_address_d = in_box1_d ? addr : '0;
        blank1_d      = blank;
    end

    // Stages 2 and 3: free-running, one pixel per cycle, no backpressure.
    always_comb begin
        in_box2_d = in_box1_q;
        blank2_d  = blank1_q;
        red_d     = 4'd0;
        green_d   = 4'd0;
        blue_d    = 4'd0;
        hit_d     = 1'b0;
        if (blank2_q && in_box2_q && (rom_q != IDX_W'(TRANSP_IDX))) begin
            red_d   = pal_red;
            green_d = pal_green;
            blue_d  = pal_blue;
            hit_d   = 1'b1;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            div_q         <= '0;
            frame_q       <= '0;
            in_box1_q     <= 1'b0;
            blank1_q      <= 1'b0;
            in_box2_q     <= 1'b0;
            blank2_q      <= 1'b0;
            rom_address_q <= '0;
            red_q         <= 4'd0;
            green_q       <= 4'd0;
            blue_q        <= 4'd0;
            hit_q         <= 1'b0;
        end else begin
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            div_q         <= div_d;
            frame_q       <= frame_d;
            in_box1_q     <= in_box1_d;
            blank1_q      <= blank1_d;
            in_box2_q     <= in_box2_d;
            blank2_q      <= blank2_d;
            rom_address_q <= rom_address_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            hit_q         <= hit_d;
        end
    end

    assign rom_address = rom_address_q;
    assign pal_index   = rom_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign hit         = hit_q;

endmodule
